ifu_axi_master: RTL and testbench

// - AXI4 read-only initiator for the instruction fetch unit: turns one fetch request (PC) into one

---
 rtl/ifu_axi_master.sv | 160 ++++++++++++++++
 tb/tb_ifu_axi_master.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_axi_master.sv
// ifu_axi_master: single-beat AXI4 read initiator for instruction fetch.
// One outstanding fetch; flush kill, misalign trap, R-phase watchdog.
module ifu_axi_master #(
  parameter logic [3:0]  AXI_ID  = 4'h0,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [1:0]  inst_resp,
  output logic        inst_timeout,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [3:0]  axi_arid,
  output logic [7:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  input  logic [63:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  input  logic        axi_rlast,
  input  logic [3:0]  axi_rid,
  output logic        axi_rready
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, AR, R, RSP} state_t;

  state_t        state, state_n;
  logic [31:0]   pc, pc_n;
  logic          kill, kill_n;
  logic          stale, stale_n;
  logic [TW-1:0] timer, timer_n;
  logic [31:0]   inst_n;
  logic [1:0]    resp_n;
  logic          to_n;
  logic          rdy_n;

  logic          fetch_fire;
  logic          r_fire;
  logic          expired;
  logic [31:0]   lane;
  logic          unused_in;

  assign fetch_fire = fetch_valid & fetch_ready;
  assign r_fire     = axi_rvalid & axi_rready;
  assign expired    = (TIMEOUT != 0) && (timer == TMAX) && !axi_rvalid;
  assign lane       = pc[2] ? axi_rdata[63:32] : axi_rdata[31:0];
  assign unused_in  = ^{axi_rlast, axi_rid};

  assign axi_araddr  = pc;
  assign axi_arvalid = (state == AR);
  assign axi_rready  = (state == R) || stale;
  assign inst_valid  = (state == RSP);
  assign axi_arid    = AXI_ID;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;

  // Register state, captured address, flags, watchdog and result payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      kill         <= 1'b0;
      stale        <= 1'b0;
      timer        <= '0;
      inst         <= '0;
      inst_resp    <= '0;
      inst_timeout <= 1'b0;
      fetch_ready  <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      kill         <= kill_n;
      stale        <= stale_n;
      timer        <= timer_n;
      inst         <= inst_n;
      inst_resp    <= resp_n;
      inst_timeout <= to_n;
      fetch_ready  <= rdy_n;
    end
  end

  // Next-state and next-payload; a stale beat is drained in any state
  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    stale_n = stale;
    timer_n = timer;
    inst_n  = inst;
    resp_n  = inst_resp;
    to_n    = inst_timeout;
    if (stale && r_fire)
      stale_n = 1'b0;
    unique case (state)
      IDLE: begin
        kill_n = 1'b0;
        if (fetch_fire) begin
          pc_n = fetch_pc;
          if (fetch_pc[1:0] != 2'b00) begin
            state_n = RSP;
            inst_n  = '0;
            resp_n  = 2'b10;
            to_n    = 1'b0;
          end else begin
            state_n = AR;
          end
        end
      end
      AR: begin
        kill_n  = kill | flush;
        timer_n = '0;
        if (axi_arready)
          state_n = R;
      end
      R: begin
        kill_n  = kill | flush;
        timer_n = timer + 1'b1;
        if (r_fire) begin
          if (kill_n) begin
            state_n = IDLE;
          end else begin
            state_n = RSP;
            inst_n  = (axi_rresp == 2'b00) ? lane : '0;
            resp_n  = axi_rresp;
            to_n    = 1'b0;
          end
        end else if (expired) begin
          stale_n = 1'b1;
          if (kill_n) begin
            state_n = IDLE;
          end else begin
            state_n = RSP;
            inst_n  = '0;
            resp_n  = 2'b11;
            to_n    = 1'b1;
          end
        end
      end
      RSP: begin
        if (inst_ready || flush)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    rdy_n = (state_n == IDLE) && !stale_n;
  end

endmodule

// File: tb/tb_ifu_axi_master.sv
// tb_ifu_axi_master: scenario tasks plus randomized fetches
// checked against a transaction-level latency/payload model.
module tb_ifu_axi_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_pc = '0;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [1:0]  inst_resp;
  logic        inst_timeout;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready = 1'b0;
  logic [3:0]  axi_arid;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic [63:0] axi_rdata = '0;
  logic [1:0]  axi_rresp = '0;
  logic        axi_rvalid = 1'b0;
  logic        axi_rlast;
  logic [3:0]  axi_rid;
  logic        axi_rready;

  assign axi_rlast = axi_rvalid;
  assign axi_rid   = 4'h0;

  always #5 clk = ~clk;

  ifu_axi_master #(.AXI_ID(4'h0), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_resp(inst_resp),
    .inst_timeout(inst_timeout),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rlast(axi_rlast), .axi_rid(axi_rid),
    .axi_rready(axi_rready)
  );

  int total = 0;
  int bad = 0;

  int          ar_wait = 0;
  int          r_wait = 0;
  logic [63:0] s_rdata = '0;
  logic [1:0]  s_rresp = '0;
  int          beats = 0;

  // Slave: arready after ar_wait AR cycles, rvalid after r_wait R cycles
  initial begin : slave
    int ar_cnt;
    int r_cnt;
    bit r_pend;
    bit r_fire_f;
    ar_cnt = 0; r_cnt = 0; r_pend = 0; r_fire_f = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi_arready = 0; axi_rvalid = 0;
        ar_cnt = 0; r_cnt = 0; r_pend = 0; r_fire_f = 0;
      end else begin
        if (r_fire_f) begin
          axi_rvalid = 0; r_pend = 0; beats++;
        end
        if (axi_arready) begin
          axi_arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
        end else if (axi_arvalid) begin
          if (ar_cnt >= ar_wait) axi_arready = 1;
          else ar_cnt++;
        end
        if (r_pend && !axi_rvalid) begin
          if (r_cnt >= r_wait) begin
            axi_rvalid = 1;
            axi_rdata = s_rdata;
            axi_rresp = s_rresp;
          end else begin
            r_cnt++;
          end
        end
        r_fire_f = axi_rvalid && axi_rready;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench time limit reached");
    $fatal(1);
  end

  task automatic do_fetch(
    input  logic [31:0] pc,
    output logic [31:0] o_inst,
    output logic [1:0]  o_resp,
    output logic        o_to,
    output int          lat,
    output bit          saw_ar,
    output bit          addr_ok,
    output bit          ok);
    int n;
    saw_ar = 0; addr_ok = 1; ok = 0; lat = 0;
    o_inst = '0; o_resp = '0; o_to = 0;
    n = 0;
    while (!fetch_ready && n < 200) begin
      @(negedge clk); n++;
    end
    if (!fetch_ready) return;
    fetch_valid = 1; fetch_pc = pc;
    @(negedge clk);
    fetch_valid = 0; fetch_pc = $urandom; lat = 1;
    while (!inst_valid && lat < 200) begin
      if (axi_arvalid) begin
        saw_ar = 1;
        if (axi_araddr !== pc) addr_ok = 0;
      end
      @(negedge clk); lat++;
    end
    if (!inst_valid) return;
    o_inst = inst; o_resp = inst_resp; o_to = inst_timeout; ok = 1;
  endtask

  task automatic consume();
    inst_ready = 1;
    @(negedge clk);
    inst_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    total++;
    if ({fetch_ready, inst_valid, axi_arvalid, axi_rready,
         inst_timeout, inst_resp, inst, axi_araddr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got fr=%b iv=%b arv=%b rr=%b inst=%h exp all 0",
               fetch_ready, inst_valid, axi_arvalid, axi_rready, inst);
    end
    rst = 0;
    total++;
    if (fetch_ready !== 1'b0) begin
      bad++; $display("FAIL reset_fr_low: got %b exp 0", fetch_ready);
    end
    @(negedge clk);
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++; $display("FAIL reset_fr_rise: got %b exp 1", fetch_ready);
    end
  endtask

  task automatic test_aligned();
    ar_wait = 0; r_wait = 0;
    s_rdata = 64'h1111_2222_3333_4444; s_rresp = 2'b00;
    fetch_valid = 1; fetch_pc = 32'h8000_0004;
    @(negedge clk);
    fetch_valid = 0;
    total++;
    if ({axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst} !==
        {1'b1, 32'h8000_0004, 4'h0, 8'h00, 3'b010, 2'b01}) begin
      bad++;
      $display("FAIL ar_phase: got v=%b a=%h id=%h len=%h sz=%b bu=%b exp 1 80000004 0 00 010 01",
               axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst);
    end
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b0) begin
      bad++; $display("FAIL early_valid: got %b exp 0", inst_valid);
    end
    @(negedge clk);
    total++;
    if ({inst_valid, inst, inst_resp, inst_timeout} !==
        {1'b1, 32'h1111_2222, 2'b00, 1'b0}) begin
      bad++;
      $display("FAIL aligned_rsp: got v=%b i=%h r=%b t=%b exp 1 11112222 00 0",
               inst_valid, inst, inst_resp, inst_timeout);
    end
    consume();
    total++;
    if (inst_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      bad++; $display("FAIL after_consume: got iv=%b fr=%b exp 0 1", inst_valid, fetch_ready);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] i; logic [1:0] r; logic t; int lat; bit sa, ao, ok;
    do_fetch(32'h8000_0002, i, r, t, lat, sa, ao, ok);
    total++;
    if (!ok || lat != 1 || sa || i !== 0 || r !== 2'b10 || t !== 0) begin
      bad++;
      $display("FAIL misaligned: got ok=%0d lat=%0d ar=%0d i=%h r=%b t=%b exp 1 1 0 0 10 0",
               ok, lat, sa, i, r, t);
    end
    consume();
  endtask

  task automatic test_error_wait();
    logic [31:0] i; logic [1:0] r; logic t; int lat; bit sa, ao, ok;
    ar_wait = 5; r_wait = 0;
    s_rdata = 64'hDEAD_BEEF_CAFE_F00D; s_rresp = 2'b10;
    do_fetch(32'hA000_0048, i, r, t, lat, sa, ao, ok);
    total++;
    if (!ok || lat != 8 || !ao || i !== 0 || r !== 2'b10 || t !== 0) begin
      bad++;
      $display("FAIL err_wait: got ok=%0d lat=%0d aok=%0d i=%h r=%b t=%b exp 1 8 1 0 10 0",
               ok, lat, ao, i, r, t);
    end
    consume();
  endtask

  task automatic test_hold_flush_rsp();
    logic [31:0] i; logic [1:0] r; logic t; int lat; bit sa, ao, ok;
    ar_wait = 1; r_wait = 2;
    s_rdata = 64'h0BAD_F00D_1234_5678; s_rresp = 2'b00;
    do_fetch(32'h0000_1000, i, r, t, lat, sa, ao, ok);
    total++;
    if (!ok || lat != 6 || i !== 32'h1234_5678 || r !== 2'b00) begin
      bad++;
      $display("FAIL hold_rsp: got ok=%0d lat=%0d i=%h r=%b exp 1 6 12345678 00",
               ok, lat, i, r);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({inst_valid, inst, inst_resp} !== {1'b1, 32'h1234_5678, 2'b00}) begin
        bad++;
        $display("FAIL hold_stable: got v=%b i=%h r=%b exp 1 12345678 00",
                 inst_valid, inst, inst_resp);
      end
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    total++;
    if (inst_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      bad++; $display("FAIL flush_rsp: got iv=%b fr=%b exp 0 1", inst_valid, fetch_ready);
    end
  endtask

  task automatic flush_scenario(input int aw, input int rw,
                                input int delay, input string name);
    int b0; bit seen;
    ar_wait = aw; r_wait = rw;
    s_rdata = {$urandom, $urandom}; s_rresp = 2'b00;
    b0 = beats; seen = 0;
    fetch_valid = 1; fetch_pc = 32'h8000_0100;
    @(negedge clk);
    fetch_valid = 0;
    repeat (delay) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    for (int k = 0; k < 25; k++) begin
      if (inst_valid) seen = 1;
      @(negedge clk);
    end
    total++;
    if (seen || beats != b0 + 1 || fetch_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: got iv_seen=%0d beats=%0d fr=%b exp 0 %0d 1",
               name, seen, beats - b0, fetch_ready, 1);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] i; logic [1:0] r; logic t; int lat; bit sa, ao, ok;
    int b0; bit early; int n;
    ar_wait = 0; r_wait = 20;
    s_rdata = {$urandom, $urandom}; s_rresp = 2'b00;
    b0 = beats;
    do_fetch(32'h8000_0200, i, r, t, lat, sa, ao, ok);
    total++;
    if (!ok || lat != 2 + TMO + 1 || i !== 0 || r !== 2'b11 || t !== 1'b1) begin
      bad++;
      $display("FAIL timeout_rsp: got ok=%0d lat=%0d i=%h r=%b t=%b exp 1 %0d 0 11 1",
               ok, lat, i, r, t, 2 + TMO + 1);
    end
    consume();
    early = 0; n = 0;
    while (n < 40) begin
      @(negedge clk); #1;
      if (fetch_ready && beats == b0) early = 1;
      if (fetch_ready) break;
      n++;
    end
    total++;
    if (early || fetch_ready !== 1'b1 || beats != b0 + 1) begin
      bad++;
      $display("FAIL stale_drain: got early=%0d fr=%b beats=%0d exp 0 1 1",
               early, fetch_ready, beats - b0);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, i, e_i; logic [1:0] r, e_r; logic t, e_t;
    int lat, e_lat; bit sa, ao, ok, e_ar;
    for (int n = 0; n < 40; n++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      ar_wait = $urandom_range(0, 3);
      r_wait  = $urandom_range(0, 12);
      s_rdata = {$urandom, $urandom};
      s_rresp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (pc[1:0] != 0) begin
        e_i = 0; e_r = 2'b10; e_t = 0; e_lat = 1; e_ar = 0;
      end else if (r_wait > TMO) begin
        e_i = 0; e_r = 2'b11; e_t = 1; e_ar = 1;
        e_lat = 1 + (ar_wait + 1) + (TMO + 1);
      end else begin
        e_r = s_rresp; e_t = 0; e_ar = 1;
        e_i = (s_rresp != 0) ? 32'h0 : (pc[2] ? s_rdata[63:32] : s_rdata[31:0]);
        e_lat = 1 + (ar_wait + 1) + (r_wait + 1);
      end
      do_fetch(pc, i, r, t, lat, sa, ao, ok);
      total++;
      if (!ok || lat != e_lat || sa != e_ar || !ao ||
          i !== e_i || r !== e_r || t !== e_t) begin
        bad++;
        $display("FAIL rand[%0d] pc=%h: got ok=%0d lat=%0d ar=%0d aok=%0d i=%h r=%b t=%b exp lat=%0d ar=%0d i=%h r=%b t=%b",
                 n, pc, ok, lat, sa, ao, i, r, t, e_lat, e_ar, e_i, e_r, e_t);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_error_wait();
    test_hold_flush_rsp();
    flush_scenario(5, 0, 1, "flush_ar");
    flush_scenario(0, 4, 2, "flush_r");
    test_timeout();
    test_random();
    repeat (30) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
